pc_update_unit: RTL and testbench

//  PC state holder fed by the PC source mux output. Owns the PC and EPC registers,

---
 rtl/pc_ctrl_pkg.sv | 55 +++++
 rtl/pc_exc_fsm.sv | 70 +++++++
 rtl/pc_update_unit.sv | 94 +++++++++
 tb/tb_pc_update_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC update path: branch encodings, exception causes and
// the exception-entry sequencer states.
package pc_ctrl_pkg;

  localparam int unsigned PcWidth  = 32;
  localparam int unsigned VecWidth = 8;

  typedef enum logic [1:0] {
    BrEq = 2'b00,
    BrNe = 2'b01,
    BrGt = 2'b10,
    BrLe = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    CauseOpcode = 2'b00,
    CauseOvf    = 2'b01,
    CauseDiv0   = 2'b10
  } exc_cause_e;

  typedef enum logic [1:0] {
    StIdle,
    StVecRd,
    StWait,
    StLoad
  } exc_state_e;

  // Fixed priority among simultaneous requests: opcode > ovf > div0.
  function automatic exc_cause_e exc_prio(input logic opcode, input logic ovf,
                                          input logic div0);
    exc_cause_e cause;
    if (opcode) begin
      cause = CauseOpcode;
    end else if (ovf) begin
      cause = CauseOvf;
    end else if (div0) begin
      cause = CauseDiv0;
    end else begin
      cause = CauseOpcode;
    end
    return cause;
  endfunction

  function automatic logic branch_taken(input branch_e bt, input logic zero, input logic gt);
    logic taken;
    unique case (bt)
      BrEq: taken = zero;
      BrNe: taken = ~zero;
      BrGt: taken = gt;
      BrLe: taken = ~gt;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_exc_fsm.sv
// Exception entry sequencer: one vector-read cycle, MEM_LAT wait cycles, then
// one load cycle in which the handler byte is written into the PC.
import pc_ctrl_pkg::*;

module pc_exc_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic exc_req,
  output logic exc_entry,
  output logic mem_rd,
  output logic exc_busy,
  output logic exc_done
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT);

  exc_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exc_entry = 1'b0;
    mem_rd    = 1'b0;
    exc_busy  = 1'b1;
    exc_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        exc_busy = 1'b0;
        if (exc_req) begin
          exc_entry = 1'b1;
          state_d   = StVecRd;
        end
      end
      StVecRd: begin
        mem_rd  = 1'b1;
        cnt_d   = CntOne;
        state_d = StWait;
      end
      StWait: begin
        // cnt_q counts wait cycles already spent, starting at 1.
        if (cnt_q == CntLast) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLoad: begin
        exc_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC/EPC state holder: applies unconditional and conditional PC loads and
// runs the exception entry sequence through pc_exc_fsm.
import pc_ctrl_pkg::*;

module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [7:0]  mem_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        exc_busy,
  output logic        exc_done
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  exc_cause_e  cause_q, cause_d;

  logic       exc_req;
  logic       exc_entry;
  logic       pc_load;
  exc_cause_e cause_new;

  assign exc_req   = exc_opcode | exc_ovf | exc_div0;
  assign cause_new = exc_prio(exc_opcode, exc_ovf, exc_div0);
  assign pc_load   = pc_write |
                     (pc_write_cond & branch_taken(branch_e'(branch_type), alu_zero, alu_gt));

  pc_exc_fsm #(
    .MEM_LAT (MEM_LAT)
  ) u_exc_fsm (
    .clk       (clk),
    .reset     (reset),
    .exc_req   (exc_req),
    .exc_entry (exc_entry),
    .mem_rd    (mem_rd),
    .exc_busy  (exc_busy),
    .exc_done  (exc_done)
  );

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    mem_addr_d = mem_addr_q;
    if (exc_done) begin
      pc_d = {{(PcWidth - VecWidth){1'b0}}, mem_data};
    end else if (exc_entry) begin
      // Entry suppresses any PC write requested on the same edge.
      epc_d      = pc_q - 32'd4;
      cause_d    = cause_new;
      mem_addr_d = VEC_BASE + {30'b0, cause_new};
    end else if (!exc_busy && pc_load) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      cause_q    <= CauseOpcode;
      mem_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign exc_cause = cause_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench: two instances (MEM_LAT=1 and 3) share stimulus; a cycle-level
// reference model queues expected outputs that a monitor checks after each edge.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset, pc_write, pc_write_cond, alu_zero, alu_gt;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [1:0]  branch_type;
  logic [31:0] pc_next;
  logic [7:0]  mem_data;

  logic [31:0] pc1, epc1, addr1, pc3, epc3, addr3;
  logic [1:0]  cause1, cause3;
  logic        rd1, busy1, done1, rd3, busy3, done3;

  always #5 clk = ~clk;

  pc_update_unit #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_type(branch_type), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .mem_data(mem_data), .pc(pc1), .epc(epc1), .exc_cause(cause1), .mem_addr(addr1),
    .mem_rd(rd1), .exc_busy(busy1), .exc_done(done1)
  );

  pc_update_unit #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_type(branch_type), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .mem_data(mem_data), .pc(pc3), .epc(epc3), .exc_cause(cause3), .mem_addr(addr3),
    .mem_rd(rd3), .exc_busy(busy3), .exc_done(done3)
  );

  typedef struct {
    logic        rst, pw, pwc, z, g, eo, ev, ed;
    logic [1:0]  bt;
    logic [31:0] nxt;
    logic [7:0]  md;
  } stim_t;

  // phase: -1 idle, otherwise cycles since exception entry.
  typedef struct {
    logic [31:0] pc, epc, addr;
    logic [1:0]  cause;
    int          phase;
  } model_t;

  typedef struct {
    logic [31:0] pc, epc, addr;
    logic [1:0]  cause;
    logic        rd, busy, done;
  } exp_t;

  exp_t   q1[$], q3[$];
  model_t m1, m3;
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic model_t model_next(input model_t m, input stim_t s, input int lat);
    model_t n = m;
    logic   cond;
    if (s.rst) begin
      n.pc = 32'h0; n.epc = 32'h0; n.addr = 32'h0; n.cause = 2'd0; n.phase = -1;
    end else if (m.phase < 0) begin
      if (s.eo || s.ev || s.ed) begin
        n.cause = s.eo ? 2'd0 : (s.ev ? 2'd1 : 2'd2);
        n.epc   = m.pc - 32'd4;
        n.addr  = 32'd253 + {30'b0, n.cause};
        n.phase = 0;
      end else begin
        case (s.bt)
          2'd0:    cond = s.z;
          2'd1:    cond = !s.z;
          2'd2:    cond = s.g;
          default: cond = !s.g;
        endcase
        if (s.pw || (s.pwc && cond)) n.pc = s.nxt;
      end
    end else if (m.phase == lat + 1) begin
      n.pc    = {24'h0, s.md};
      n.phase = -1;
    end else begin
      n.phase = m.phase + 1;
    end
    return n;
  endfunction

  function automatic exp_t expect_of(input model_t m, input int lat);
    exp_t e;
    e.pc = m.pc; e.epc = m.epc; e.addr = m.addr; e.cause = m.cause;
    e.rd   = (m.phase == 0);
    e.busy = (m.phase >= 0);
    e.done = (m.phase == lat + 1);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s = '{default: '0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    @(negedge clk);
    reset = s.rst; pc_write = s.pw; pc_write_cond = s.pwc; branch_type = s.bt;
    alu_zero = s.z; alu_gt = s.g; exc_opcode = s.eo; exc_ovf = s.ev; exc_div0 = s.ed;
    pc_next = s.nxt; mem_data = s.md;
    m1 = model_next(m1, s, 1);
    m3 = model_next(m3, s, 3);
    q1.push_back(expect_of(m1, 1));
    q3.push_back(expect_of(m3, 3));
    @(posedge clk);
  endtask

  task automatic compare_out(input string tag, input exp_t e, input logic [31:0] pc,
                             input logic [31:0] epc, input logic [31:0] addr,
                             input logic [1:0] cause, input logic rd, input logic busy,
                             input logic done);
    check({tag, "_pc"}, pc, e.pc);
    check({tag, "_epc"}, epc, e.epc);
    check({tag, "_cause"}, {30'b0, cause}, {30'b0, e.cause});
    check({tag, "_mem_rd"}, {31'b0, rd}, {31'b0, e.rd});
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, e.busy});
    check({tag, "_done"}, {31'b0, done}, {31'b0, e.done});
    if (e.busy) check({tag, "_mem_addr"}, addr, e.addr);
  endtask

  // Monitor: outputs are presented every cycle; compare 1 ns after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare_out("lat1", e, pc1, epc1, addr1, cause1, rd1, busy1, done1);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        compare_out("lat3", e, pc3, epc3, addr3, cause3, rd3, busy3, done3);
      end
    end
  end

  initial begin
    stim_t       s;
    int          busy_cycles1, busy_cycles3;
    logic [31:0] prev_pc;
    logic        taken;
    m1 = '{default: '0};
    m3 = '{default: '0};
    m1.phase = -1;
    m3.phase = -1;

    // Reset and its values.
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    #1;
    check("reset_pc", pc1, 32'h0);
    check("reset_epc", epc1, 32'h0);
    check("reset_mem_addr", addr1, 32'h0);
    s = idle(); step(s);

    // Unconditional load, then failed beq.
    s = idle(); s.pw = 1'b1; s.nxt = 32'h40; step(s);
    #1; check("pc_write_0x40", pc1, 32'h40);
    s = idle(); s.pwc = 1'b1; s.bt = 2'd0; s.z = 1'b0; s.nxt = 32'h80; step(s);
    #1; check("beq_not_taken", pc1, 32'h40);

    // All branch types against both flag values.
    for (int bt = 0; bt < 4; bt++) begin
      for (int fl = 0; fl < 4; fl++) begin
        prev_pc = pc1;
        s = idle(); s.pwc = 1'b1; s.bt = 2'(bt); s.z = fl[0]; s.g = fl[1];
        s.nxt = 32'h1000 + 32'(bt * 16 + fl * 4);
        step(s);
        #1;
        case (bt)
          0:       taken = s.z;
          1:       taken = !s.z;
          2:       taken = s.g;
          default: taken = !s.g;
        endcase
        check("branch_cond", pc1, taken ? s.nxt : prev_pc);
      end
    end

    // Overflow exception racing a pc_write.
    s = idle(); s.pw = 1'b1; s.nxt = 32'h104; step(s);
    s = idle(); s.ev = 1'b1; s.pw = 1'b1; s.nxt = 32'hDEADBEEF; s.md = 8'h7C; step(s);
    #1;
    check("ovf_epc", epc1, 32'h100);
    check("ovf_cause", {30'b0, cause1}, 32'd1);
    check("ovf_mem_addr", addr1, 32'd254);
    check("ovf_mem_rd", {31'b0, rd1}, 32'd1);
    check("ovf_pc_held", pc1, 32'h104);
    s = idle(); s.md = 8'h7C; step(s);
    #1; check("ovf_mem_rd_one_cycle", {31'b0, rd1}, 32'd0);
    step(s);
    #1; check("ovf_done_pulse", {31'b0, done1}, 32'd1);
    step(s);
    #1;
    check("ovf_handler_pc", pc1, 32'h7C);
    check("ovf_done_cleared", {31'b0, done1}, 32'd0);
    step(s); step(s);
    #1; check("ovf_handler_pc_lat3", pc3, 32'h7C);

    // All requests together; requests during busy are ignored.
    s = idle(); s.eo = 1'b1; s.ev = 1'b1; s.ed = 1'b1; s.md = 8'h11; step(s);
    #1;
    check("prio_cause", {30'b0, cause1}, 32'd0);
    check("prio_mem_addr", addr1, 32'd253);
    check("prio_epc", epc1, 32'h78);
    s = idle(); s.ev = 1'b1; s.pw = 1'b1; s.nxt = 32'h5555; s.md = 8'h11;
    step(s); step(s);
    #1; check("busy_ignores_req_epc", epc1, 32'h78);
    s = idle(); s.md = 8'h11;
    step(s);
    #1; check("busy_ignores_pc_write", pc1, 32'h11);
    step(s); step(s); step(s);

    // Wrap-around EPC and busy length at both latencies.
    s = idle(); s.pw = 1'b1; s.nxt = 32'h0; step(s);
    s = idle(); s.ed = 1'b1; step(s);
    #1;
    check("div0_epc_wrap", epc3, 32'hFFFFFFFC);
    check("div0_mem_addr", addr3, 32'd255);
    busy_cycles1 = 0;
    busy_cycles3 = 0;
    s = idle();
    for (int i = 0; i < 10; i++) begin
      if (busy1) busy_cycles1++;
      if (busy3) busy_cycles3++;
      step(s);
      #1;
    end
    check("busy_len_lat1", busy_cycles1, 32'd3);
    check("busy_len_lat3", busy_cycles3, 32'd5);

    // Reset in the middle of WAIT aborts the sequence.
    s = idle(); s.pw = 1'b1; s.nxt = 32'h200; step(s);
    s = idle(); s.ev = 1'b1; s.md = 8'h33; step(s);
    s = idle(); s.md = 8'h33; step(s);
    #1; check("wait_before_reset", {31'b0, busy1}, 32'd1);
    s = idle(); s.rst = 1'b1; s.md = 8'h33; step(s);
    #1;
    check("midwait_reset_pc", pc1, 32'h0);
    check("midwait_reset_busy1", {31'b0, busy1}, 32'd0);
    check("midwait_reset_busy3", {31'b0, busy3}, 32'd0);
    check("midwait_reset_epc", epc3, 32'h0);
    s = idle(); step(s); step(s);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      s.pw  = ($urandom_range(0, 3) == 0);
      s.pwc = 1'($urandom);
      s.bt  = 2'($urandom);
      s.z   = 1'($urandom);
      s.g   = 1'($urandom);
      s.eo  = ($urandom_range(0, 23) == 0);
      s.ev  = ($urandom_range(0, 23) == 0);
      s.ed  = ($urandom_range(0, 23) == 0);
      s.nxt = $urandom;
      s.md  = 8'($urandom);
      step(s);
    end

    s = idle(); step(s);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q1.size() + q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
